// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared stall-bus, stage-index and flush-FSM definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_STALL_W = 6;
    typedef logic [c_STALL_W-1:0] stall_bus_t;

    localparam logic c_STOP   = 1'b1;
    localparam logic c_NOSTOP = 1'b0;

    localparam int c_STG_PC  = 0;
    localparam int c_STG_IF  = 1;
    localparam int c_STG_ID  = 2;
    localparam int c_STG_EX  = 3;
    localparam int c_STG_MEM = 4;
    localparam int c_STG_WB  = 5;

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_FLUSH = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_MASK  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_stall_merge.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_stall_merge
// Description : Merges stall requests into a thermometer stall vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_stall_merge
    import pipeline_ctrl_pkg::*;
#(
    parameter int                   STALL_W   = 6,
    parameter int                   NUM_REQ   = 3,
    parameter logic [8*NUM_REQ-1:0] REQ_STAGE = {8'd4, 8'd3, 8'd1}
) (
    input  logic [NUM_REQ-1:0] stallreq,
    output logic [STALL_W-1:0] stall
);

    logic [STALL_W-1:0] w_therm [NUM_REQ];

    // OR of thermometer codes equals the thermometer of the deepest stage.
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_src
            localparam int c_RAW = int'(REQ_STAGE[8*k +: 8]);
            localparam int c_STG = (c_RAW >= STALL_W) ? STALL_W - 1 : c_RAW;
            localparam logic [STALL_W-1:0] c_THERM =
                {STALL_W{c_STOP}} >> (STALL_W - 1 - c_STG);
            assign w_therm[k] = stallreq[k] ? c_THERM : {STALL_W{c_NOSTOP}};
        end
    endgenerate

    always_comb begin
        stall = {STALL_W{c_NOSTOP}};
        for (int k = 0; k < NUM_REQ; k++) begin
            stall = stall | w_therm[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard/flush controller: stall merge, flush FSM, counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int                   STALL_W   = 6,
    parameter int                   NUM_REQ   = 3,
    parameter logic [8*NUM_REQ-1:0] REQ_STAGE = {8'd4, 8'd3, 8'd1},
    parameter int                   TIMEOUT   = 1024,
    parameter int                   CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] stallreq,
    input  logic               excp_valid,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               stall_timeout
);

    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_TIMEOUT = c_WD_W'(TIMEOUT);

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_state_nxt;
    logic [31:0]        r_new_pc;
    logic [STALL_W-1:0] w_merged;
    logic [STALL_W-1:0] w_stall;
    logic               w_flush;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_WD_W-1:0]  r_wd;
    logic [c_WD_W-1:0]  w_wd_nxt;
    logic               r_timeout;

    pipeline_ctrl_stall_merge #(
        .STALL_W   (STALL_W),
        .NUM_REQ   (NUM_REQ),
        .REQ_STAGE (REQ_STAGE)
    ) u_merge (
        .stallreq (stallreq),
        .stall    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_new_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE && excp_valid) begin
                r_new_pc <= excp_pc;
            end
        end
    end

    // Exceptions seen in FLUSH/MASK come from wrong-path instructions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (excp_valid) w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: w_state_nxt = c_ST_MASK;
            c_ST_MASK:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_flush = (r_state == c_ST_FLUSH);
        w_stall = (rst || w_flush) ? {STALL_W{c_NOSTOP}} : w_merged;
    end

    always_comb begin
        w_wd_nxt = r_wd;
        if (w_stall == '0 || w_flush) begin
            w_wd_nxt = '0;
        end else if (r_wd != c_TIMEOUT) begin
            w_wd_nxt = r_wd + c_WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_stall != '0 && r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_wd      <= w_wd_nxt;
            r_timeout <= r_timeout | (w_wd_nxt == c_TIMEOUT);
        end
    end

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign new_pc        = r_new_pc;
    assign stall_cnt     = r_cnt;
    assign stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed, table-driven bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  stallreq;
    logic        excp_valid;
    logic [31:0] excp_pc;

    logic [5:0]  stall_m, stall_w, stall_s;
    logic        flush_m, flush_w, flush_s;
    logic [31:0] new_pc_m, new_pc_w, new_pc_s;
    logic [31:0] cnt_m, cnt_w;
    logic [3:0]  cnt_s;
    logic        to_m, to_w, to_s;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] req;
        logic [5:0] exp_stall;
    } vec_t;
    vec_t vecs [8];

    pipeline_ctrl u_dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .stall(stall_m), .flush(flush_m), .new_pc(new_pc_m),
        .stall_cnt(cnt_m), .stall_timeout(to_m)
    );

    pipeline_ctrl #(.TIMEOUT(8)) u_dut_wd (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .stall(stall_w), .flush(flush_w), .new_pc(new_pc_w),
        .stall_cnt(cnt_w), .stall_timeout(to_w)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .stall(stall_s), .flush(flush_s), .new_pc(new_pc_s),
        .stall_cnt(cnt_s), .stall_timeout(to_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic ev,
                         input logic [31:0] pc);
        stallreq   = req;
        excp_valid = ev;
        excp_pc    = pc;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 1'b0, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int exp_cnt;

        vecs[0] = '{3'b001, 6'b000011};
        vecs[1] = '{3'b010, 6'b001111};
        vecs[2] = '{3'b100, 6'b011111};
        vecs[3] = '{3'b000, 6'b000000};
        vecs[4] = '{3'b011, 6'b001111};
        vecs[5] = '{3'b101, 6'b011111};
        vecs[6] = '{3'b110, 6'b011111};
        vecs[7] = '{3'b111, 6'b011111};

        // Reset held with every request active: outputs stay quiet.
        rst = 1'b1;
        drive(3'b111, 1'b1, 32'hCAFE_F00D);
        cyc();
        for (int i = 0; i < 3; i++) begin
            check("rst_stall", 32'(stall_m), 32'h0);
            check("rst_flush", 32'(flush_m), 32'h0);
            check("rst_new_pc", new_pc_m, 32'h0);
            check("rst_cnt", cnt_m, 32'h0);
            check("rst_timeout", 32'(to_m), 32'h0);
            cyc();
        end
        rst = 1'b0;
        drive(3'b000, 1'b0, 32'h0);
        check("post_rst_flush0", 32'(flush_m), 32'h0);
        cyc();
        check("post_rst_flush1", 32'(flush_m), 32'h0);

        // Table: combinational stall merge and cumulative stall count.
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req, 1'b0, 32'h0);
            check($sformatf("vec%0d_stall", i), 32'(stall_m), 32'(vecs[i].exp_stall));
            cyc();
            if (vecs[i].exp_stall != 6'd0) exp_cnt++;
            check($sformatf("vec%0d_cnt", i), cnt_m, 32'(exp_cnt));
        end

        // Merge held five cycles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'b011, 1'b0, 32'h0);
            check("merge_stall", 32'(stall_m), 32'h0F);
            cyc();
        end
        drive(3'b000, 1'b0, 32'h0);
        check("merge_cnt5", cnt_m, 32'd5);

        // Flush sequencing with masked follow-up exceptions.
        do_reset();
        drive(3'b100, 1'b1, 32'hBFC0_0380);
        check("t0_stall_honoured", 32'(stall_m), 32'h1F);
        check("t0_flush", 32'(flush_m), 32'h0);
        cyc();
        drive(3'b100, 1'b1, 32'hDEAD_0000);
        check("t1_flush", 32'(flush_m), 32'h1);
        check("t1_new_pc", new_pc_m, 32'hBFC0_0380);
        check("t1_stall_forced0", 32'(stall_m), 32'h0);
        cyc();
        drive(3'b000, 1'b1, 32'h1234_5678);
        check("t2_flush", 32'(flush_m), 32'h0);
        check("t2_cnt", cnt_m, 32'd1);
        cyc();
        drive(3'b000, 1'b1, 32'h0000_1000);
        check("t3_flush", 32'(flush_m), 32'h0);
        cyc();
        drive(3'b000, 1'b0, 32'h0);
        check("t4_flush", 32'(flush_m), 32'h1);
        check("t4_new_pc", new_pc_m, 32'h0000_1000);
        cyc();
        check("t5_flush", 32'(flush_m), 32'h0);
        check("t5_new_pc_hold", new_pc_m, 32'h0000_1000);

        // Watchdog fires on the 8th consecutive stalled edge.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(3'b001, 1'b0, 32'h0);
            cyc();
            if (i == 7) check("wd_edge7", 32'(to_w), 32'h0);
        end
        check("wd_edge8", 32'(to_w), 32'h1);
        check("wd_main_quiet", 32'(to_m), 32'h0);
        drive(3'b000, 1'b0, 32'h0);
        cyc();
        cyc();
        check("wd_sticky", 32'(to_w), 32'h1);

        // 7 stalled, 1 idle, 7 stalled never reaches the limit.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive((i == 7) ? 3'b000 : 3'b001, 1'b0, 32'h0);
            cyc();
        end
        check("wd_gap", 32'(to_w), 32'h0);

        // Counter saturation and reset during FLUSH.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(3'b010, 1'b0, 32'h0);
            cyc();
        end
        drive(3'b000, 1'b0, 32'h0);
        check("sat_cnt4", 32'(cnt_s), 32'd15);
        check("sat_cnt32", cnt_m, 32'd20);
        drive(3'b000, 1'b1, 32'hA5A5_0000);
        cyc();
        drive(3'b000, 1'b0, 32'h0);
        check("pre_rst_flush", 32'(flush_m), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(3'b000, 1'b0, 32'h0);
        check("rst_in_flush", 32'(flush_m), 32'h0);
        check("rst_in_flush_pc", new_pc_m, 32'h0);
        cyc();
        check("rst_in_flush_after", 32'(flush_m), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
